// File: rtl/leds_racer_core_n.sv
// leds_racer_core_n: N-player race engine with per-channel debounce, menu join timer,
// position counting, winner detection and end-screen hold. Optional GAME idle abort: LEDS_RACER_IDLE_ABORT_EN.
module leds_racer_core_n #(
  parameter int NUM_PLAYERS          = 4,
  parameter int MAX_POS              = 109,
  parameter int DEBOUNCE_CLK_CNT     = 65536,
  parameter int MENU_TIMER_CLK_COUNT = 50000000,
  parameter int END_TIMER_CLK_COUNT  = 750000000,
  localparam int POS_W = $clog2(MAX_POS + 1),
  localparam int WID_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PLAYERS-1:0]       player_btn,
  output logic [1:0]                   screen,
  output logic [NUM_PLAYERS-1:0]       ready_to_play,
  output logic [NUM_PLAYERS*POS_W-1:0] positions,
  output logic [WID_W-1:0]             winner_id,
  output logic                         winner_valid,
  output logic                         update_frame
);

  localparam int DB_W = (DEBOUNCE_CLK_CNT > 1) ? $clog2(DEBOUNCE_CLK_CNT) : 1;
  localparam int MT_W = (MENU_TIMER_CLK_COUNT > 1) ? $clog2(MENU_TIMER_CLK_COUNT) : 1;
  localparam int ET_W = (END_TIMER_CLK_COUNT > 1) ? $clog2(END_TIMER_CLK_COUNT) : 1;

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CLK_CNT - 1);
  localparam logic [MT_W-1:0]  MT_LAST = MT_W'(MENU_TIMER_CLK_COUNT - 1);
  localparam logic [ET_W-1:0]  ET_LAST = ET_W'(END_TIMER_CLK_COUNT - 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(MAX_POS);

  typedef enum logic [1:0] {
    S_MENU = 2'd0,
    S_GAME = 2'd1,
    S_END  = 2'd2
  } state_t;

  logic [NUM_PLAYERS-1:0]       r_sync1;
  logic [NUM_PLAYERS-1:0]       r_sync2;
  logic [NUM_PLAYERS-1:0]       r_deb;
  logic [DB_W-1:0]              r_db_cnt [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]       w_press;
  logic [NUM_PLAYERS-1:0]       w_acc;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [NUM_PLAYERS-1:0]       r_ready;
  logic [NUM_PLAYERS-1:0]       w_ready_nxt;
  logic [NUM_PLAYERS*POS_W-1:0] r_pos;
  logic [NUM_PLAYERS*POS_W-1:0] w_pos_nxt;
  logic [WID_W-1:0]             r_wid;
  logic [WID_W-1:0]             w_wid_nxt;
  logic                         r_wvld;
  logic                         w_wvld_nxt;
  logic [MT_W-1:0]              r_menu_tmr;
  logic [MT_W-1:0]              w_menu_tmr_nxt;
  logic [ET_W-1:0]              r_end_tmr;
  logic [ET_W-1:0]              w_end_tmr_nxt;
`ifdef LEDS_RACER_IDLE_ABORT_EN
  logic [ET_W-1:0]              r_idle_tmr;
  logic [ET_W-1:0]              w_idle_tmr_nxt;
`endif
  logic                         w_hit;
  logic                         w_chg;
  logic                         r_chg_p0;
  logic                         r_uf_p1;

  // Input stage: 2-FF synchroniser feeding a per-channel stability counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= player_btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // The press fires in the cycle the debounced level is about to rise, so the game
  // logic consumes it on the same edge that r_deb flips.
  always_comb begin
    w_press = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      w_press[i] = r_sync2[i] & ~r_deb[i] & (r_db_cnt[i] == DB_LAST);
  end

  assign w_acc = w_press & r_ready;

  // Game stage: next-state and datapath decode
  always_comb begin
    w_state_nxt    = r_state;
    w_ready_nxt    = r_ready;
    w_pos_nxt      = r_pos;
    w_wid_nxt      = r_wid;
    w_wvld_nxt     = r_wvld;
    w_menu_tmr_nxt = '0;
    w_end_tmr_nxt  = '0;
`ifdef LEDS_RACER_IDLE_ABORT_EN
    w_idle_tmr_nxt = '0;
`endif
    w_hit          = 1'b0;
    case (r_state)
      S_MENU: begin
        w_ready_nxt = r_ready | w_press;
        if (r_ready != '0) begin
          if (r_menu_tmr == MT_LAST) w_state_nxt = S_GAME;
          else                       w_menu_tmr_nxt = r_menu_tmr + MT_W'(1);
        end
      end
      S_GAME: begin
        for (int i = 0; i < NUM_PLAYERS; i++)
          if (w_acc[i] && (r_pos[i*POS_W +: POS_W] != POS_MAX))
            w_pos_nxt[i*POS_W +: POS_W] = r_pos[i*POS_W +: POS_W] + POS_W'(1);
        // Scan from the top so the lowest arriving index is the one left latched.
        for (int i = NUM_PLAYERS - 1; i >= 0; i--)
          if (w_pos_nxt[i*POS_W +: POS_W] == POS_MAX) begin
            w_hit     = 1'b1;
            w_wid_nxt = WID_W'(i);
          end
        if (w_hit) begin
          w_state_nxt = S_END;
          w_wvld_nxt  = 1'b1;
        end
`ifdef LEDS_RACER_IDLE_ABORT_EN
        else if (w_acc == '0) begin
          if (r_idle_tmr == ET_LAST) begin
            w_state_nxt = S_MENU;
            w_ready_nxt = '0;
            w_pos_nxt   = '0;
          end else begin
            w_idle_tmr_nxt = r_idle_tmr + ET_W'(1);
          end
        end
`endif
      end
      S_END: begin
        if (r_end_tmr == ET_LAST) begin
          w_state_nxt = S_MENU;
          w_ready_nxt = '0;
          w_pos_nxt   = '0;
          w_wid_nxt   = '0;
          w_wvld_nxt  = 1'b0;
        end else begin
          w_end_tmr_nxt = r_end_tmr + ET_W'(1);
        end
      end
      default: w_state_nxt = S_MENU;
    endcase
  end

  assign w_chg = (w_state_nxt != r_state) | (w_ready_nxt != r_ready) | (w_pos_nxt != r_pos);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_MENU;
    else       r_state <= w_state_nxt;
  end

  // Register stage: game state, timers and redraw strobe pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready    <= '0;
      r_pos      <= '0;
      r_wid      <= '0;
      r_wvld     <= 1'b0;
      r_menu_tmr <= '0;
      r_end_tmr  <= '0;
`ifdef LEDS_RACER_IDLE_ABORT_EN
      r_idle_tmr <= '0;
`endif
      r_chg_p0   <= 1'b0;
      r_uf_p1    <= 1'b0;
    end else begin
      r_ready    <= w_ready_nxt;
      r_pos      <= w_pos_nxt;
      r_wid      <= w_wid_nxt;
      r_wvld     <= w_wvld_nxt;
      r_menu_tmr <= w_menu_tmr_nxt;
      r_end_tmr  <= w_end_tmr_nxt;
`ifdef LEDS_RACER_IDLE_ABORT_EN
      r_idle_tmr <= w_idle_tmr_nxt;
`endif
      r_chg_p0   <= w_chg;
      r_uf_p1    <= r_chg_p0;
    end
  end

  assign screen        = r_state;
  assign ready_to_play = r_ready;
  assign positions     = r_pos;
  assign winner_id     = r_wid;
  assign winner_valid  = r_wvld;
  assign update_frame  = r_uf_p1;

endmodule

// File: tb/tb_leds_racer_core_n.sv
// Bench for leds_racer_core_n: directed vector table, hand-written corner sequences,
// and randomized button traffic checked cycle by cycle against an event-level model.
module tb_leds_racer_core_n;
  localparam int NP = 4;
  localparam int MP = 5;
  localparam int DB = 4;
  localparam int MT = 20;
  localparam int ET = 30;
  localparam int PW = 3;
  localparam int WW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NP-1:0] btn = '0;
  logic [1:0]    screen;
  logic [NP-1:0] ready_to_play;
  logic [NP*PW-1:0] positions;
  logic [WW-1:0] winner_id;
  logic          winner_valid;
  logic          update_frame;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  leds_racer_core_n #(
    .NUM_PLAYERS(NP), .MAX_POS(MP), .DEBOUNCE_CLK_CNT(DB),
    .MENU_TIMER_CLK_COUNT(MT), .END_TIMER_CLK_COUNT(ET)
  ) dut (
    .clk(clk), .reset(reset), .player_btn(btn), .screen(screen),
    .ready_to_play(ready_to_play), .positions(positions), .winner_id(winner_id),
    .winner_valid(winner_valid), .update_frame(update_frame)
  );

  // Reference model: a clean press of DB samples becomes an event 2 edges after
  // its last required sample; game rules use absolute deadlines in edge numbers.
  int            n;
  int            run_len [NP];
  int            pend [NP];
  int            m_scr;
  logic [NP-1:0] m_rdy;
  int            m_pos [NP];
  int            m_wid;
  logic          m_wv;
  int            menu_dl, end_dl, idle_dl;
  logic [17:0]   snap1, snap2;

  function automatic logic [NP*PW-1:0] pack_pos();
    logic [NP*PW-1:0] p;
    p = '0;
    for (int i = 0; i < NP; i++) p[i*PW +: PW] = PW'(m_pos[i]);
    return p;
  endfunction

  function automatic logic [17:0] snap();
    return {m_scr[1:0], m_rdy, pack_pos()};
  endfunction

  function automatic logic [21:0] exp_out();
    return {m_scr[1:0], m_rdy, pack_pos(), m_wv, m_wid[1:0], (snap1 != snap2)};
  endfunction

  function automatic logic [21:0] act_out();
    return {screen, ready_to_play, positions, winner_valid, winner_id, update_frame};
  endfunction

  task automatic model_reset();
    n = 0; m_scr = 0; m_rdy = '0; m_wid = 0; m_wv = 1'b0;
    menu_dl = -1; end_dl = -1; idle_dl = -1;
    for (int i = 0; i < NP; i++) begin run_len[i] = 0; pend[i] = -1; m_pos[i] = 0; end
    snap1 = '0; snap2 = '0;
  endtask

  task automatic model_step(input logic [NP-1:0] b);
    logic [NP-1:0] ev, acc;
    int w;
    n++;
    ev = '0;
    for (int i = 0; i < NP; i++) begin
      run_len[i] = b[i] ? run_len[i] + 1 : 0;
      if (run_len[i] == DB) pend[i] = n + 2;
      if (pend[i] == n) ev[i] = 1'b1;
    end
    snap2 = snap1;
    snap1 = snap();
    acc = ev & m_rdy;
    case (m_scr)
      0: begin
        if (m_rdy != '0 && n == menu_dl) begin m_scr = 1; idle_dl = n + ET; end
        if (m_rdy == '0 && ev != '0) menu_dl = n + MT;
        m_rdy = m_rdy | ev;
      end
      1: begin
        for (int i = 0; i < NP; i++) if (acc[i] && m_pos[i] < MP) m_pos[i]++;
        w = -1;
        for (int i = 0; i < NP; i++) if (w < 0 && m_pos[i] == MP) w = i;
        if (w >= 0) begin
          m_scr = 2; m_wv = 1'b1; m_wid = w; end_dl = n + ET;
        end
`ifdef LEDS_RACER_IDLE_ABORT_EN
        else if (acc != '0) idle_dl = n + ET;
        else if (n == idle_dl) begin
          m_scr = 0; m_rdy = '0;
          for (int i = 0; i < NP; i++) m_pos[i] = 0;
        end
`endif
      end
      default: begin
        if (n == end_dl) begin
          m_scr = 0; m_rdy = '0; m_wv = 1'b0; m_wid = 0;
          for (int i = 0; i < NP; i++) m_pos[i] = 0;
        end
      end
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run(input logic [NP-1:0] b, input int k);
    btn = b;
    repeat (k) begin
      @(posedge clk);
      model_step(b);
      #1;
    end
  endtask

  task automatic step_cmp(input logic [NP-1:0] b);
    btn = b;
    @(posedge clk);
    model_step(b);
    #1;
    chk($sformatf("rand_edge%0d", n), 32'(act_out()), 32'(exp_out()));
  endtask

  typedef struct {
    logic [3:0]  b;
    int          hold;
    int          waitc;
    logic [1:0]  scr;
    logic [3:0]  rdy;
    logic [11:0] pos;
    logic        wv;
    logic [1:0]  wid;
  } vec_t;

  vec_t tbl [13];
  int   ufc;
  logic [NP-1:0] mask;
  int   hold, gap;

  initial begin
    // join window, race to win, END hold and return to MENU
    tbl[0]  = '{4'b0001, 6, 4,  2'd0, 4'b0001, 12'h000, 1'b0, 2'd0};
    tbl[1]  = '{4'b0100, 6, 4,  2'd0, 4'b0101, 12'h000, 1'b0, 2'd0};
    tbl[2]  = '{4'b0000, 0, 5,  2'd0, 4'b0101, 12'h000, 1'b0, 2'd0};
    tbl[3]  = '{4'b0000, 0, 1,  2'd1, 4'b0101, 12'h000, 1'b0, 2'd0};
    tbl[4]  = '{4'b1000, 6, 6,  2'd1, 4'b0101, 12'h000, 1'b0, 2'd0};
    tbl[5]  = '{4'b0001, 6, 6,  2'd1, 4'b0101, 12'h001, 1'b0, 2'd0};
    tbl[6]  = '{4'b0001, 6, 6,  2'd1, 4'b0101, 12'h002, 1'b0, 2'd0};
    tbl[7]  = '{4'b0001, 6, 6,  2'd1, 4'b0101, 12'h003, 1'b0, 2'd0};
    tbl[8]  = '{4'b0001, 6, 6,  2'd1, 4'b0101, 12'h004, 1'b0, 2'd0};
    tbl[9]  = '{4'b0001, 6, 6,  2'd2, 4'b0101, 12'h005, 1'b1, 2'd0};
    tbl[10] = '{4'b0100, 6, 6,  2'd2, 4'b0101, 12'h005, 1'b1, 2'd0};
    tbl[11] = '{4'b0000, 0, 11, 2'd2, 4'b0101, 12'h005, 1'b1, 2'd0};
    tbl[12] = '{4'b0000, 0, 1,  2'd0, 4'b0000, 12'h000, 1'b0, 2'd0};

    model_reset();
    do_reset();
    chk("reset_outputs", 32'(act_out()), 32'd0);
    ufc = 0;
    repeat (100) begin
      run('0, 1);
      if (update_frame !== 1'b0 || screen !== 2'd0) ufc++;
    end
    chk("reset_idle_quiet", 32'(ufc), 32'd0);

    // debounce: short glitch rejected, clean press lands 6 edges after the edge
    run(4'b0010, 3);
    run('0, 20);
    chk("glitch_ready", 32'(ready_to_play), 32'd0);
    run(4'b0010, 5);
    chk("deb_ready_early", 32'(ready_to_play), 32'd0);
    run(4'b0010, 1);
    chk("deb_ready", 32'(ready_to_play), 32'b0010);
    chk("deb_uf_before", 32'(update_frame), 32'd0);
    run(4'b0010, 1);
    chk("deb_uf_pulse", 32'(update_frame), 32'd1);
    run(4'b0010, 1);
    chk("deb_uf_single", 32'(update_frame), 32'd0);

    do_reset();
    for (int k = 0; k < 13; k++) begin
      run(tbl[k].b, tbl[k].hold);
      run('0, tbl[k].waitc);
      chk($sformatf("vec%0d", k), 32'({screen, ready_to_play, positions, winner_valid, winner_id}),
          32'({tbl[k].scr, tbl[k].rdy, tbl[k].pos, tbl[k].wv, tbl[k].wid}));
    end

    // tie at the finish line: lowest index wins
    do_reset();
    run(4'b0101, 6); run('0, 6); run('0, 14);
    chk("tie_game", 32'(screen), 32'd1);
    repeat (4) begin run(4'b0101, 6); run('0, 6); end
    chk("tie_pos4", 32'(positions), 32'h104);
    run(4'b0101, 6); run('0, 6);
    chk("tie_screen", 32'(screen), 32'd2);
    chk("tie_pos5", 32'(positions), 32'h145);
    chk("tie_winner", 32'({winner_valid, winner_id}), 32'b100);

    // asynchronous reset mid-race
    do_reset();
    run(4'b0001, 6); run('0, 20);
    run(4'b0001, 6); run('0, 6);
    chk("mid_pre", 32'({screen, positions}), 32'({2'd1, 12'h001}));
    reset = 1'b1;
    #1;
    chk("mid_reset", 32'(act_out()), 32'd0);

    // idle GAME behaviour
    do_reset();
    run(4'b0001, 6); run('0, 20);
    run('0, 29);
    chk("idle_still_game", 32'(screen), 32'd1);
    run('0, 1);
`ifdef LEDS_RACER_IDLE_ABORT_EN
    chk("idle_abort", 32'({screen, ready_to_play, winner_valid}), 32'd0);
    run('0, 1);
    chk("idle_abort_uf", 32'(update_frame), 32'd1);
`else
    chk("idle_no_abort", 32'(screen), 32'd1);
    run('0, 40);
    chk("idle_no_abort_late", 32'(screen), 32'd1);
`endif

    // randomized traffic against the model
    for (int t = 0; t < 5; t++) begin
      do_reset();
      for (int s = 0; s < 40; s++) begin
        mask = NP'($urandom_range(0, 15));
        hold = $urandom_range(1, 8);
        gap  = $urandom_range(6, 14);
        repeat (hold) step_cmp(mask);
        repeat (gap) step_cmp('0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
